// File: rtl/rv32_instr_encoder.sv
// rv32_instr_encoder: packs decoded RV32I fields into 32-bit instruction words,
// buffers them in a small FIFO and streams them out with an auto-incrementing
// byte address. Unsupported opcodes are consumed but raise a sticky error.
module rv32_instr_encoder #(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [15:0]       emitted
);

  // Opcode values of the supported formats
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Pointer index width; one extra wrap bit distinguishes full from empty
  localparam int PW = $clog2(DEPTH);

  logic [PW:0]   wr_ptr_reg;
  logic [PW:0]   rd_ptr_reg;
  logic [31:0]   mem_reg [DEPTH];
  logic [31:0]   enc_word;
  logic          enc_legal;
  logic          full;
  logic          empty;
  logic          accept;
  logic          push;
  logic          pop;
  logic [ADDR_W-1:0] addr_reg;
  logic [15:0]   emitted_reg;
  logic          err_reg;

  assign full  = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                 (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
  assign empty = (wr_ptr_reg == rd_ptr_reg);

  // No bypass: a full FIFO refuses input even if the head is popped this cycle
  assign in_ready  = !full;
  assign accept    = in_valid && in_ready;
  assign push      = accept && enc_legal;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  // Combinational field packing, selected by opcode
  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b1;
    case (opcode)
      OP_R: begin
        enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      OP_LOAD, OP_JALR: begin
        enc_word = {imm[11:0], rs1, funct3, rd, opcode};
      end
      OP_IMM: begin
        // Shift-immediate forms carry funct7 in the upper immediate bits
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          enc_word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        end else begin
          enc_word = {imm[11:0], rs1, funct3, rd, opcode};
        end
      end
      OP_STORE: begin
        enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      end
      OP_BRANCH: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      end
      OP_JAL: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      end
      OP_LUI, OP_AUIPC: begin
        enc_word = {imm[31:12], rd, opcode};
      end
      default: begin
        enc_legal = 1'b0;
      end
    endcase
  end

  // Storage entries: each written only when it is the current write slot
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg[PW-1:0] == PW'(gi))) begin
          mem_reg[gi] <= enc_word;
        end
      end
    end
  endgenerate

  // FIFO pointers; reset discards everything buffered
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + (PW+1)'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + (PW+1)'(1);
    end
  end

  // Address and handed-off count advance only on a pop
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg    <= BASE_ADDR;
      emitted_reg <= 16'h0;
    end else if (pop) begin
      addr_reg <= addr_reg + ADDR_W'(4);
      if (emitted_reg != 16'hFFFF) emitted_reg <= emitted_reg + 16'h1;
    end
  end

  // Sticky error for any accepted bundle with an unsupported opcode
  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (accept && !enc_legal) begin
      err_reg <= 1'b1;
    end
  end

  // Head entry cannot be overwritten while buffered, so this stays stable under stall
  assign out_instr = empty ? 32'h0 : mem_reg[rd_ptr_reg[PW-1:0]];
  assign out_addr  = addr_reg;
  assign emitted   = emitted_reg;
  assign err       = err_reg;

endmodule
